// File: rtl/hist_pkg.sv
// Shared constants, FSM encoding and sizing helper for the hist_calc histogram engine.
package hist_pkg;

    localparam int NUM_BINS = 256;

    localparam logic [8:0] CLEAR_CYCLES = 9'd256;
    localparam logic [8:0] FLUSH_CYCLES = 9'd3;
    localparam logic [8:0] CDF_CYCLES   = 9'd257;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        FLUSH = 3'd3,
        CDF   = 3'd4,
        DONE  = 3'd5
    } hist_state_e;

    // One extra bit over the pixel address so a single bin can hold every pixel.
    function automatic int bin_width(input int addr_bits);
        return addr_bits + 1;
    endfunction

endpackage

// File: rtl/hist_bram.sv
// 256-entry simple dual-port bin memory: one write port, one registered read port.
module hist_bram
    import hist_pkg::*;
#(
    parameter int BIN_W = 13
) (
    input  logic             clk,
    input  logic             we,
    input  logic [7:0]       wa,
    input  logic [BIN_W-1:0] wd,
    input  logic [7:0]       ra,
    output logic [BIN_W-1:0] rd
);

    logic [BIN_W-1:0] mem_r [NUM_BINS];
    logic [BIN_W-1:0] rd_r;

    // Write port and read-first registered read port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[wa] <= wd;
        end
        rd_r <= mem_r[ra];
    end

    assign rd = rd_r;

endmodule

// File: rtl/hist_calc.sv
// Image histogram engine streaming W*H pixels at one per clock into a 256-bin RAM.
// Optional macro HIST_CDF_EN turns the histogram into a cumulative distribution in place.
module hist_calc
    import hist_pkg::*;
#(
    parameter int W               = 64,
    parameter int H               = 64,
    parameter int TOTAL_PIXEL_BIT = $clog2(W*H),
    parameter int BIN_W           = bin_width(TOTAL_PIXEL_BIT)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [TOTAL_PIXEL_BIT-1:0] pix_addr,
    input  logic [7:0]                 pix_data,
    output logic                       busy,
    output logic                       done,
    input  logic [7:0]                 hist_rd_addr,
    output logic [BIN_W-1:0]           hist_rd_data
);

    localparam logic [TOTAL_PIXEL_BIT-1:0] LAST_ADDR = TOTAL_PIXEL_BIT'(W*H-1);

    hist_state_e state_r, state_next;
    logic [8:0]                 cnt_r, cnt_next;
    logic                       busy_r, done_r;
    logic [TOTAL_PIXEL_BIT-1:0] pix_addr_r;

    logic                       v1_r, v2_r, lw_v_r;
    logic [7:0]                 pix2_r, lw_pix_r;
    logic [BIN_W-1:0]           lw_val_r;
    logic [BIN_W-1:0]           inc_s;

    logic                       we_s;
    logic [7:0]                 wa_s, ra_s;
    logic [BIN_W-1:0]           wd_s, rd_s;

`ifdef HIST_CDF_EN
    logic [BIN_W-1:0]           acc_r;
    logic [BIN_W-1:0]           cdf_sum_s;
    assign cdf_sum_s = acc_r + rd_s;
`endif

    // Next-state and phase counter.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r + 9'd1;
        case (state_r)
            IDLE: begin
                cnt_next = 9'd0;
                if (start) begin
                    state_next = CLEAR;
                end else begin
                    state_next = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_r == CLEAR_CYCLES - 9'd1) begin
                    state_next = RUN;
                    cnt_next   = 9'd0;
                end else begin
                    state_next = CLEAR;
                end
            end
            RUN: begin
                cnt_next = 9'd0;
                if (pix_addr_r == LAST_ADDR) begin
                    state_next = FLUSH;
                end else begin
                    state_next = RUN;
                end
            end
            FLUSH: begin
                if (cnt_r == FLUSH_CYCLES - 9'd1) begin
`ifdef HIST_CDF_EN
                    state_next = CDF;
`else
                    state_next = DONE;
`endif
                    cnt_next   = 9'd0;
                end else begin
                    state_next = FLUSH;
                end
            end
`ifdef HIST_CDF_EN
            CDF: begin
                if (cnt_r == CDF_CYCLES - 9'd1) begin
                    state_next = DONE;
                    cnt_next   = 9'd0;
                end else begin
                    state_next = CDF;
                end
            end
`endif
            DONE: begin
                state_next = IDLE;
                cnt_next   = 9'd0;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 9'd0;
            end
        endcase
    end

    // The bin read during the previous write stage is stale; forward that write instead.
    always_comb begin
        if (lw_v_r && (lw_pix_r == pix2_r)) begin
            inc_s = lw_val_r + BIN_W'(1);
        end else begin
            inc_s = rd_s + BIN_W'(1);
        end
    end

    // Bin RAM port ownership: sequencer while busy, result read port otherwise.
    always_comb begin
        we_s = 1'b0;
        wa_s = 8'd0;
        wd_s = '0;
        if (state_r == CLEAR) begin
            we_s = 1'b1;
            wa_s = cnt_r[7:0];
        end else if (v2_r) begin
            we_s = 1'b1;
            wa_s = pix2_r;
            wd_s = inc_s;
`ifdef HIST_CDF_EN
        end else if ((state_r == CDF) && (cnt_r != 9'd0)) begin
            we_s = 1'b1;
            wa_s = cnt_r[7:0] - 8'd1;
            wd_s = cdf_sum_s;
`endif
        end else begin
            we_s = 1'b0;
        end

        if (v1_r) begin
            ra_s = pix_data;
`ifdef HIST_CDF_EN
        end else if (state_r == CDF) begin
            ra_s = cnt_r[7:0];
`endif
        end else if (busy_r) begin
            ra_s = 8'd0;
        end else begin
            ra_s = hist_rd_addr;
        end
    end

    // State, handshake outputs, address generator and pixel pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= IDLE;
            cnt_r      <= 9'd0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            pix_addr_r <= '0;
            v1_r       <= 1'b0;
            v2_r       <= 1'b0;
            lw_v_r     <= 1'b0;
            pix2_r     <= 8'd0;
            lw_pix_r   <= 8'd0;
            lw_val_r   <= '0;
        end else begin
            state_r    <= state_next;
            cnt_r      <= cnt_next;
            busy_r     <= (state_next != IDLE);
            done_r     <= (state_r == DONE);
            pix_addr_r <= ((state_r == RUN) && (state_next == RUN)) ? pix_addr_r + TOTAL_PIXEL_BIT'(1) : '0;
            v1_r       <= (state_r == RUN);
            v2_r       <= v1_r;
            lw_v_r     <= v2_r;
            pix2_r     <= pix_data;
            lw_pix_r   <= pix2_r;
            lw_val_r   <= inc_s;
        end
    end

`ifdef HIST_CDF_EN
    // Running prefix sum for the in-place cumulative pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if ((state_r == CDF) && (cnt_r != 9'd0)) begin
            acc_r <= cdf_sum_s;
        end else if (state_r != CDF) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_r;
        end
    end
`endif

    hist_bram #(.BIN_W(BIN_W)) u_bram (
        .clk (clk),
        .we  (we_s),
        .wa  (wa_s),
        .wd  (wd_s),
        .ra  (ra_s),
        .rd  (rd_s)
    );

    assign pix_addr     = pix_addr_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign hist_rd_data = rd_s;

endmodule

// File: tb/tb_hist_calc.sv
// Self-checking bench for hist_calc: directed and random images against a counting model.
module tb_hist_calc;

    localparam int W   = 64;
    localparam int H   = 64;
    localparam int N   = W * H;
    localparam int TPB = $clog2(N);
    localparam int BW  = TPB + 1;
`ifdef HIST_CDF_EN
    localparam int EXP_LAT = 256 + N + 4 + 257;
`else
    localparam int EXP_LAT = 256 + N + 4;
`endif
    localparam int TIMEOUT = EXP_LAT + 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [TPB-1:0] pix_addr;
    logic [7:0]     pix_data;
    logic           busy;
    logic           done;
    logic [7:0]     hist_rd_addr;
    logic [BW-1:0]  hist_rd_data;

    int errors = 0;
    int checks = 0;

    logic [7:0] img [N];
    int         exp_bin [256];
    int         pat [8] = '{5, 5, 5, 7, 5, 7, 7, 9};

    hist_calc #(.W(W), .H(H)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pix_addr     (pix_addr),
        .pix_data     (pix_data),
        .busy         (busy),
        .done         (done),
        .hist_rd_addr (hist_rd_addr),
        .hist_rd_data (hist_rd_data)
    );

    always #5 clk = ~clk;

    // Upstream pixel RAM with one-cycle read latency.
    always @(posedge clk) pix_data <= img[pix_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // kind: 0 zero, 1 ramp, 2 hazard pattern, 3 random full range, 4 random narrow
    task automatic fill_image(input int kind);
        for (int i = 0; i < N; i++) begin
            case (kind)
                0:       img[i] = 8'd0;
                1:       img[i] = 8'(i % 256);
                2:       img[i] = 8'(pat[i % 8]);
                3:       img[i] = 8'($urandom_range(0, 255));
                default: img[i] = 8'($urandom_range(4, 6));
            endcase
        end
        foreach (exp_bin[k]) exp_bin[k] = 0;
        for (int i = 0; i < N; i++) exp_bin[img[i]] += 1;
`ifdef HIST_CDF_EN
        for (int k = 1; k < 256; k++) exp_bin[k] += exp_bin[k-1];
`endif
    endtask

    task automatic do_run(input string tag, input int restart_at);
        int cyc;
        bit seen;
        bit extra;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < TIMEOUT) begin
            start = (cyc == restart_at);
            @(posedge clk);
            #1;
            cyc++;
            if (cyc == 256 + 37) chk({tag, "_pix_addr"}, 32'(pix_addr), 32'd37);
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
        chk({tag, "_latency"}, 32'(cyc), 32'(EXP_LAT));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
        chk({tag, "_pix_addr_idle"}, 32'(pix_addr), 32'd0);
        if (restart_at >= 0) begin
            extra = 1'b0;
            repeat (300) begin
                @(posedge clk);
                #1;
                if (done || busy) extra = 1'b1;
            end
            chk({tag, "_single_done"}, 32'(extra), 32'd0);
        end
    endtask

    task automatic check_bins(input string tag);
        for (int k = 0; k < 256; k++) begin
            @(negedge clk);
            hist_rd_addr = 8'(k);
            @(posedge clk);
            #1;
            chk($sformatf("%s_bin%0d", tag, k), 32'(hist_rd_data), 32'(exp_bin[k]));
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        hist_rd_addr = 8'd0;
        foreach (img[i]) img[i] = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_pix_addr", 32'(pix_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        fill_image(0);
        do_run("zero", -1);
        check_bins("zero");

        fill_image(1);
        do_run("ramp", -1);
        repeat (20) @(posedge clk);
        check_bins("ramp");

        fill_image(2);
        do_run("hazard", -1);
        check_bins("hazard");

        fill_image(3);
        do_run("rand", -1);
        check_bins("rand");

        fill_image(4);
        do_run("narrow", -1);
        check_bins("narrow");

        fill_image(2);
        do_run("restart", 256 + 1000);
        check_bins("restart");

        // Abort mid-RUN, then a clean ramp run.
        fill_image(3);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (256 + 200) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_pix_addr", 32'(pix_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        fill_image(1);
        do_run("after_rst", -1);
        check_bins("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hist_calc.md
HIST_CALC -- requirements
Module: hist_calc

Interface
REQ-001 SHALL have parameter W, default 64: image width in pixels.
REQ-002 SHALL have parameter H, default 64: image height in pixels.
REQ-003 SHALL have parameter TOTAL_PIXEL_BIT, default $clog2(W*H): pixel address width.
REQ-004 SHALL have parameter BIN_W, default TOTAL_PIXEL_BIT+1: bin count width, which holds W*H without overflow.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1 bit: one-cycle request to compute the histogram of the full image.
REQ-008 SHALL have port pix_addr, output, TOTAL_PIXEL_BIT bits: read address to the upstream pixel RAM.
REQ-009 SHALL have port pix_data, input, 8 bits: pixel value, valid exactly one cycle after pix_addr.
REQ-010 SHALL have port busy, output, 1 bit: high from the cycle after an accepted start until done.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse when the histogram is complete.
REQ-012 SHALL have port hist_rd_addr, input, 8 bits: result bin index.
REQ-013 SHALL have port hist_rd_data, output, BIN_W bits: bin count, one-cycle read latency, valid only while busy=0.

Function
REQ-014 SHALL implement the FSM states IDLE, CLEAR, RUN, FLUSH, CDF and DONE.
REQ-015 IDLE SHALL go to CLEAR on start=1; start SHALL be ignored in every other state.
REQ-016 CLEAR SHALL write zero to bins 0..255, one per cycle, for 256 cycles, then go to RUN.
REQ-017 RUN SHALL issue pix_addr = 0..W*H-1, one address per cycle with no gaps, then go to FLUSH.
REQ-018 The pixel pipeline SHALL be: cycle n, address issued; n+1, pix_data sampled and bin read; n+2, bin+1 written.
REQ-019 The block SHALL sustain a throughput of 1 pixel/clk.
REQ-020 Read-after-write hazard: when a pixel equals the pixel in the write stage, the block SHALL forward the incremented value instead of the stale RAM data, so that runs of equal pixels count exactly.
REQ-021 FLUSH SHALL last 3 cycles to drain the pipeline, then go to CDF (macro on) or DONE (macro off).
REQ-022 DONE SHALL assert done=1 for one cycle, then go to IDLE; busy SHALL fall in the same cycle done rises.
REQ-023 Without the macro, done SHALL assert 256 + W*H + 4 cycles after the cycle start was sampled.
REQ-024 The bin counter SHALL be BIN_W wide, with no saturation needed.
REQ-025 While busy=1 the internal sequencer SHALL own the bin RAM port, and hist_rd_data SHALL be don't-care.
REQ-026 Results SHALL persist in IDLE until the next start.
REQ-027 pix_addr SHALL hold 0 outside RUN.

Reset
REQ-028 rst=1 at any clock edge SHALL force IDLE, busy=0, done=0, pix_addr=0, and clear the pipeline valids.
REQ-029 Bin contents after reset SHALL be undefined until the next CLEAR.
REQ-030 Reset mid-operation SHALL abort cleanly, and a subsequent start SHALL yield a correct histogram.

Configuration
REQ-031 Macro HIST_CDF_EN defined: the CDF state SHALL walk bins 0..255 in place, bin[k] = bin[k] + bin[k-1], in 257 cycles (read/accumulate pipeline), so bin 255 = W*H; done SHALL then be 257 cycles later than REQ-023.
REQ-032 Macro HIST_CDF_EN undefined: the CDF state and its logic SHALL be absent, and FLUSH SHALL go directly to DONE.

Structure
REQ-033 Package hist_pkg SHALL hold NUM_BINS=256, the FSM state encoding, the CLEAR_CYCLES/FLUSH_CYCLES/CDF_CYCLES constants, and a bin-width helper function.
REQ-034 A single sub-module, hist_bram, SHALL be used: a 256 x BIN_W simple dual-port RAM (1 write port, 1 registered read port), inferred as block RAM.
REQ-035 hist_bram SHALL be muxed between the sequencer and the hist_rd_addr port.

Verification
REQ-036 All-zero image, start -> bin0 = 4096, bins 1..255 = 0, done exactly at the REQ-023 cycle count.
REQ-037 Ramp image, pixel[i] = i mod 256 -> every bin = 16.
REQ-038 Hazard image with repeating pattern 5,5,5,7,5,7,7,9 -> bin5 = 2048, bin7 = 1536, bin9 = 512, all others 0.
REQ-039 start pulsed again mid-RUN -> ignored, result unchanged, single done pulse.
REQ-040 rst asserted mid-RUN, then start after two idle cycles -> ramp result correct, bin = 16 each.
REQ-041 HIST_CDF_EN with ramp image -> bin[k] = 16*(k+1), bin255 = 4096, done 257 cycles later than without the macro.
